vector_mask_packer: RTL and testbench
=====================================

Name: vector_mask_packer

Overview:
- Sits downstream of vector_add_unit for mask-producing ops (vmadc/vmsbc, with and without carry/borrow-in).
- Each beat, the add unit returns 1/2/4/8 carry/borrow bits in vd[7:0], depending on SEW.
- This block accepts those beats over a valid/ready handshake and packs them, in element order, into one 64-bit mask word for the vector register file write port.
- Tail elements (index >= vl) are forced to zero.

Parameters:
- MASK_WIDTH, 64, width of the packed mask word and maximum element count per operation (fixed at 64 for this revision).
- VL_WIDTH, 7, width of the vl input (holds 0..64).

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins an operation; sampled only in IDLE
- sew  input  2  element width: 00=8, 01=16, 10=32, 11=64; sampled at start
- vl  input  VL_WIDTH  element count; sampled at start; values >64 clamp to 64
- in_valid  input  1  beat from add unit valid
- in_ready  output  1  packer accepts beat
- in_mask  input  8  vd[7:0] from add unit; only the low epb bits are used
- out_valid  output  1  packed mask word valid
- out_ready  input  1  register-file writer accepts word
- out_mask  output  MASK_WIDTH  packed mask word
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on the output handshake

Behaviour:
- epb (elements per beat): 8 for sew=00, 4 for 01, 2 for 10, 1 for 11.
- Reset (asynchronous, reset_n=0): state=IDLE; all outputs 0; the accumulator, element counter and latched sew/vl clear to 0.
- States are IDLE, COLLECT and OUTPUT.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: latch sew and min(vl,64); clear the accumulator and elem_cnt.
  - Next state is COLLECT if vl>0, else OUTPUT (word = 0).
- COLLECT:
  - in_ready=1.
  - Beat accepted when in_valid & in_ready: for i in 0..epb-1, acc[elem_cnt+i] = in_mask[i] if (elem_cnt+i) < vl, else 0.
  - elem_cnt += epb.
  - If the new elem_cnt >= vl, go to OUTPUT on the next edge.
  - in_mask bits at index >= epb are ignored.
- OUTPUT:
  - out_valid=1, out_mask=acc, in_ready=0.
  - out_valid is first high the cycle after the last beat is accepted (1-cycle latency).
  - out_mask is held stable while out_ready=0.
  - On out_valid & out_ready: done=1 for that cycle; next state is IDLE; out_valid drops on the next edge.
- start is ignored while busy=1; there is no queuing.
- Beat count per operation = ceil(vl/epb). Maximum is 64 beats (sew=11, vl=64).
- elem_cnt is 8 bits wide, so overshoot to 64+7 cannot wrap.
- out_mask bits [63:vl] are always 0.
- Assertion of reset_n mid-operation returns to IDLE immediately.
  - A partial word is discarded; no out_valid or done is produced.
- in_valid asserted while in IDLE or OUTPUT has no effect.

Test Plan:
1. sew=00, vl=16; beats in_mask=0xA5 then 0x3C -> out_mask=0x0000_0000_0000_3CA5; out_valid the cycle after the second accept; done pulses with out_ready=1.
2. sew=11, vl=3; beats in_mask=0xFF,0x00,0x01 (bit0 only used) -> out_mask=0x5; exactly 3 beats accepted, in_ready=0 afterward.
3. sew=01, vl=6; beats 0xFF,0xFF -> out_mask=0x3F (tail bits 6,7 zeroed, upper in_mask nibble ignored).
4. sew=10, vl=4; out_ready held low for 5 cycles -> out_valid=1 and out_mask=0xF stable throughout; start pulse during hold is ignored; done occurs only on the cycle out_ready rises.
5. vl=0 with any sew -> no beats accepted; out_valid=1 with out_mask=0 on the cycle after start; vl=100 at sew=00 -> 8 beats, all 64 bits taken from in_mask.
6. sew=00, vl=64; reset_n pulsed low after the 3rd beat -> busy=0, out_valid=0 and out_mask=0 immediately. A fresh start then packs cleanly with no residue from the aborted operation.

Source files
------------

// File: rtl/vector_mask_packer.sv
// Packs per-beat carry/borrow bits from the vector add unit into one 64-bit
// mask word, zeroing tail elements at or beyond vl.
module vector_mask_packer #(
   parameter int MASK_WIDTH = 64,
   parameter int VL_WIDTH   = 7
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [1:0]            sew,
   input  logic [VL_WIDTH-1:0]   vl,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_mask,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [MASK_WIDTH-1:0] out_mask,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   state_t                state_r;
   logic [1:0]            sew_r;
   logic [VL_WIDTH-1:0]   vl_r;
   logic [7:0]            elem_cnt_r;
   logic [MASK_WIDTH-1:0] acc_r;
   logic                  in_ready_r;
   logic                  out_valid_r;
   logic                  busy_r;

   logic [3:0]            epb_s;
   logic [VL_WIDTH-1:0]   vl_clamp_s;
   logic [7:0]            cnt_next_s;
   logic [7:0]            idx_s;
   logic                  take_s;
   logic [MASK_WIDTH-1:0] acc_next_s;

   // Elements per beat for the latched element width.
   always_comb begin
      epb_s = 4'd1;
      case (sew_r)
         2'b00:   epb_s = 4'd8;
         2'b01:   epb_s = 4'd4;
         2'b10:   epb_s = 4'd2;
         2'b11:   epb_s = 4'd1;
         default: epb_s = 4'd1;
      endcase
   end

   assign vl_clamp_s = (vl > 7'd64) ? 7'd64 : vl;
   assign cnt_next_s = elem_cnt_r + {4'd0, epb_s};

   // Merge the beat into the accumulator; lanes past epb or past vl keep the cleared value.
   always_comb begin
      acc_next_s = acc_r;
      idx_s      = 8'd0;
      take_s     = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx_s  = elem_cnt_r + 8'(i);
         take_s = (4'(i) < epb_s) && (idx_s < {1'b0, vl_r});
         acc_next_s[idx_s[5:0]] = take_s ? in_mask[i] : acc_next_s[idx_s[5:0]];
      end
   end

   // Control FSM with registered handshake and status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         sew_r       <= 2'b00;
         vl_r        <= 7'd0;
         elem_cnt_r  <= 8'd0;
         acc_r       <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  sew_r      <= sew;
                  vl_r       <= vl_clamp_s;
                  elem_cnt_r <= 8'd0;
                  acc_r      <= '0;
                  busy_r     <= 1'b1;
                  if (vl_clamp_s != 7'd0) begin
                     state_r    <= COLLECT;
                     in_ready_r <= 1'b1;
                  end else begin
                     state_r     <= OUTPUT;
                     out_valid_r <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (in_valid && in_ready_r) begin
                  acc_r      <= acc_next_s;
                  elem_cnt_r <= cnt_next_s;
                  if (cnt_next_s >= {1'b0, vl_r}) begin
                     state_r     <= OUTPUT;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_mask  = acc_r;
   assign busy      = busy_r;
   // done marks the accepted output handshake in the same cycle it happens.
   assign done      = out_valid_r & out_ready;

endmodule

// File: tb/tb_vector_mask_packer.sv
// Self-checking bench for vector_mask_packer: directed cases plus randomized
// operations checked against an element-indexed reference model.
module tb_vector_mask_packer;

   logic        clock     = 1'b0;
   logic        reset_n   = 1'b0;
   logic        start     = 1'b0;
   logic [1:0]  sew       = 2'b00;
   logic [6:0]  vl        = 7'd0;
   logic        in_valid  = 1'b0;
   logic [7:0]  in_mask   = 8'd0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic        done;
   logic [63:0] out_mask;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  beats [64];

   vector_mask_packer #(.MASK_WIDTH(64), .VL_WIDTH(7)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .sew(sew), .vl(vl),
      .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Element e of the operation is bit (e mod epb) of beat (e div epb).
   function automatic logic [63:0] model(input logic [1:0] s, input int v);
      int vc;
      int epb;
      logic [63:0] m;
      vc  = (v > 64) ? 64 : v;
      epb = 8 >> s;
      m   = '0;
      for (int e = 0; e < vc; e++) m[e] = beats[e / epb][e % epb];
      return m;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 64; i++) beats[i] = 8'($urandom);
   endtask

   task automatic run_op(input logic [1:0] s, input int v, input int stall,
                         input bit gaps, input bit start_in_hold);
      int vc, epb, nb, acc, guard;
      logic [63:0] exp;
      vc  = (v > 64) ? 64 : v;
      epb = 8 >> s;
      nb  = (vc + epb - 1) / epb;
      exp = model(s, v);
      @(negedge clock);
      start = 1'b1; sew = s; vl = 7'(v);
      @(negedge clock);
      start = 1'b0; sew = 2'($urandom); vl = 7'($urandom);
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      acc = 0;
      guard = 0;
      while (acc < nb && guard < 500) begin
         chk("in_ready_collect", {63'd0, in_ready}, 64'd1);
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_mask  = in_valid ? beats[acc] : 8'($urandom);
         if (in_valid) acc++;
         guard++;
         @(negedge clock);
      end
      chk("beat_budget", 64'(acc), 64'(nb));
      in_valid = 1'b1;
      in_mask  = 8'($urandom);
      chk("out_valid_latency", {63'd0, out_valid}, 64'd1);
      chk("in_ready_output", {63'd0, in_ready}, 64'd0);
      chk("out_mask", out_mask, exp);
      for (int k = 0; k < stall; k++) begin
         out_ready = 1'b0;
         start     = start_in_hold && (k == 1);
         @(negedge clock);
         chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_out_mask", out_mask, exp);
         chk("hold_done", {63'd0, done}, 64'd0);
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("handshake_mask", out_mask, exp);
      @(negedge clock);
      out_ready = 1'b0;
      chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_done", {63'd0, done}, 64'd0);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
   endtask

   initial begin
      #1;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
      chk("reset_out_mask", out_mask, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // 1: two byte-wide beats
      fill_random();
      beats[0] = 8'hA5; beats[1] = 8'h3C;
      run_op(2'b00, 16, 0, 1'b0, 1'b0);

      // 2: sew=64, only bit0 of each beat counts
      fill_random();
      beats[0] = 8'hFF; beats[1] = 8'h00; beats[2] = 8'h01;
      run_op(2'b11, 3, 1, 1'b0, 1'b0);

      // 3: tail lanes zeroed
      fill_random();
      beats[0] = 8'hFF; beats[1] = 8'hFF;
      run_op(2'b01, 6, 0, 1'b0, 1'b0);

      // 4: output held with a stray start
      fill_random();
      beats[0] = 8'hFF; beats[1] = 8'hFF;
      run_op(2'b10, 4, 5, 1'b0, 1'b1);

      // 5: empty and over-long vl
      fill_random();
      run_op(2'($urandom), 0, 2, 1'b0, 1'b0);
      fill_random();
      run_op(2'b00, 100, 0, 1'b1, 1'b0);
      fill_random();
      run_op(2'b11, 64, 1, 1'b1, 1'b0);

      // 6: reset in the middle of an operation
      fill_random();
      @(negedge clock);
      start = 1'b1; sew = 2'b00; vl = 7'd64;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_mask  = beats[i];
         @(negedge clock);
      end
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_out_mask", out_mask, 64'd0);
      chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("abort_stays_idle", {63'd0, busy}, 64'd0);
      fill_random();
      run_op(2'b00, 64, 0, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         int st;
         fill_random();
         st = $urandom_range(0, 4);
         run_op(2'($urandom), $urandom_range(0, 100), st, 1'b1, st >= 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
